// File: rtl/seq_scan_pkg.sv
// Shared state encodings, default parameters and sizing helper for seq_scan_ctrl.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_PAT_LEN = 3;
  localparam int DEF_COUNT_W = 4;

  // Bit counter must hold the value WIDTH itself, hence the +1.
  function automatic int bcnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_window.sv
// Sliding-window pattern detector: history, fill counter and comparator; hit is combinational.
// Optional SEQ_SCAN_NOOVERLAP_EN clears the window on every hit (non-overlapping detection).
module seq_window
  import seq_scan_pkg::*;
#(
  parameter int PAT_LEN = DEF_PAT_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic [PAT_LEN-1:0] pattern,
  output logic               hit
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);
  localparam logic [FW-1:0] FILL_THR = FW'(PAT_LEN - 1);

  // Only the older PAT_LEN-1 bits need storage; the newest bit arrives on bit_in.
  logic [PAT_LEN-2:0] r_hist;
  logic [FW-1:0]      r_fill;
  logic [PAT_LEN-1:0] w_hist_nxt;
  logic [FW-1:0]      w_fill_nxt;

  assign w_hist_nxt = {r_hist, bit_in};
  assign w_fill_nxt = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
  assign hit        = bit_valid && (r_fill >= FILL_THR) && (w_hist_nxt == pattern);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (bit_valid) begin
`ifdef SEQ_SCAN_NOOVERLAP_EN
      if (hit) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_hist_nxt[PAT_LEN-2:0];
        r_fill <= w_fill_nxt;
      end
`else
      r_hist <= w_hist_nxt[PAT_LEN-2:0];
      r_fill <= w_fill_nxt;
`endif
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan scheduler: latches a word and pattern, feeds the word MSB-first into seq_window, counts hits.
// SEQ_SCAN_NOOVERLAP_EN (in seq_window) selects non-overlapping detection.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [PAT_LEN-1:0] pattern,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] match_count,
  output logic               match_pulse,
  output logic               serial_bit
);

  localparam int BCW = bcnt_w(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("seq_scan_ctrl: WIDTH must be in 2..32");
  end
  if (PAT_LEN < 2 || PAT_LEN > WIDTH) begin : g_bad_pat
    $error("seq_scan_ctrl: PAT_LEN must be in 2..WIDTH");
  end
  if ((64'd1 << COUNT_W) <= 64'(WIDTH)) begin : g_bad_cnt
    $error("seq_scan_ctrl: 2**COUNT_W must exceed WIDTH");
  end

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_shreg;
  logic [PAT_LEN-1:0] r_pat;
  logic [BCW-1:0]     r_bcnt;
  logic [COUNT_W-1:0] r_count;
  logic               r_mpulse;

  logic w_accept;
  logic w_shift;
  logic w_last;
  logic w_serial;
  logic w_hit;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_shift  = (r_state == ST_SHIFT);
  assign w_last   = (r_bcnt == BCW'(1));
  assign w_serial = w_shift ? r_shreg[WIDTH-1] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Unused encoding 2'b11 falls to the default arm and recovers to IDLE.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next = start ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: w_next = w_last ? ST_DONE : ST_SHIFT;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != ST_IDLE);
    done        = (r_state == ST_DONE);
    serial_bit  = w_serial;
    match_count = r_count;
    match_pulse = r_mpulse;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg  <= '0;
      r_pat    <= '0;
      r_bcnt   <= '0;
      r_count  <= '0;
      r_mpulse <= 1'b0;
    end else begin
      r_mpulse <= w_hit;
      if (w_accept) begin
        r_shreg <= data_in;
        r_pat   <= pattern;
        r_bcnt  <= BCW'(WIDTH);
        r_count <= '0;
      end else if (w_shift) begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        r_bcnt  <= r_bcnt - 1'b1;
        if (w_hit) begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  seq_window #(
    .PAT_LEN (PAT_LEN)
  ) u_window (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_accept),
    .bit_valid (w_shift),
    .bit_in    (w_serial),
    .pattern   (r_pat),
    .hit       (w_hit)
  );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed vector table, corner sequences, random scans vs. model.
module tb_seq_scan_ctrl;

  localparam int W  = 8;
  localparam int P  = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  data_in;
  logic [P-1:0]  pattern;
  logic          busy;
  logic          done;
  logic [CW-1:0] match_count;
  logic          match_pulse;
  logic          serial_bit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl #(
    .WIDTH   (W),
    .PAT_LEN (P),
    .COUNT_W (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .data_in     (data_in),
    .pattern     (pattern),
    .busy        (busy),
    .done        (done),
    .match_count (match_count),
    .match_pulse (match_pulse),
    .serial_bit  (serial_bit)
  );

  typedef struct {
    logic [W-1:0] d;
    logic [P-1:0] p;
    int           exp;
    bit           hold;
    bit           scramble;
    string        name;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: slide a P-bit window over the word MSB-first; non-overlapping mode skips past each match.
  function automatic int model_count(input logic [W-1:0] d, input logic [P-1:0] p);
    int n = 0;
    int s = 0;
    logic [W-1:0] sh;
    while (s + P <= W) begin
      sh = d << s;
      if (sh[W-1 -: P] == p) begin
        n++;
`ifdef SEQ_SCAN_NOOVERLAP_EN
        s += P;
`else
        s++;
`endif
      end else begin
        s++;
      end
    end
    return n;
  endfunction

  task automatic run_scan(input string nm, input logic [W-1:0] d, input logic [P-1:0] p,
                          input int exp, input bit hold, input bit scramble);
    int done_cnt = 0;
    int done_at = -1;
    int busy_cyc = 0;
    int pulses = 0;
    int cnt_at_done = -1;
    int ser_bad = 0;
    int wait_cyc = 0;
    logic [W-1:0] sh;
    @(negedge clk);
    data_in = d;
    pattern = p;
    start   = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= W + 1; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (scramble) begin
        data_in = W'($urandom);
        pattern = P'($urandom);
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        done_at = k;
        cnt_at_done = int'(match_count);
      end
      if (match_pulse) pulses++;
      sh = d << k;
      if (serial_bit !== sh[W-1]) ser_bad++;
    end
    check({nm, " done_count"}, done_cnt, 1);
    check({nm, " done_latency"}, done_at, W);
    check({nm, " busy_cycles"}, busy_cyc, W + 1);
    check({nm, " match_count"}, cnt_at_done, exp);
    check({nm, " match_pulses"}, pulses, exp);
    check({nm, " serial_bits_bad"}, ser_bad, 0);
    check({nm, " idle_after_done"}, int'(busy), 0);
    check({nm, " count_held"}, int'(match_count), exp);
    if (hold) begin
      @(negedge clk);
      check({nm, " restart_from_idle"}, int'(busy), 1);
      start = 1'b0;
      while (busy && wait_cyc < W + 4) begin
        @(negedge clk);
        wait_cyc++;
      end
      check({nm, " second_scan_ends"}, int'(busy), 0);
    end
  endtask

  initial begin
    int dcnt;
    logic [W-1:0] rd;
    logic [P-1:0] rp;

`ifdef SEQ_SCAN_NOOVERLAP_EN
    vecs[0] = '{8'b10101010, 3'b101, 2, 1'b0, 1'b0, "alt101"};
    vecs[1] = '{8'hFF,       3'b111, 2, 1'b0, 1'b0, "dense111"};
`else
    vecs[0] = '{8'b10101010, 3'b101, 3, 1'b0, 1'b0, "alt101"};
    vecs[1] = '{8'hFF,       3'b111, 6, 1'b0, 1'b0, "dense111"};
`endif
    vecs[2] = '{8'h00,       3'b101, 0, 1'b0, 1'b0, "nomatch"};
    vecs[3] = '{8'hF0,       3'b100, 1, 1'b1, 1'b0, "held_start"};
    vecs[4] = '{8'h0F,       3'b011, 1, 1'b0, 1'b1, "scrambled_inputs"};

    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;
    pattern = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset match_count", int'(match_count), 0);
    check("reset match_pulse", int'(match_pulse), 0);
    check("reset serial_bit", int'(serial_bit), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle without start", int'(busy), 0);

    for (int i = 0; i < 5; i++) begin
      run_scan(vecs[i].name, vecs[i].d, vecs[i].p, vecs[i].exp, vecs[i].hold, vecs[i].scramble);
    end

    // Mid-scan reset: one match lands at the third shift edge, reset hits the fourth SHIFT cycle.
    @(negedge clk);
    data_in = 8'b10101010;
    pattern = 3'b101;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset count_before", int'(match_count), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy", int'(busy), 0);
    check("midreset match_count", int'(match_count), 0);
    check("midreset done", int'(done), 0);
    check("midreset serial_bit", int'(serial_bit), 0);
    dcnt = 0;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("midreset no_done_or_busy", dcnt, 0);
`ifdef SEQ_SCAN_NOOVERLAP_EN
    run_scan("after_reset", 8'b10101010, 3'b101, 2, 1'b0, 1'b0);
`else
    run_scan("after_reset", 8'b10101010, 3'b101, 3, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      rd = W'($urandom);
      rp = P'($urandom);
      run_scan($sformatf("rand%0d_%02h_%0b", i, rd, rp), rd, rp, model_count(rd, rp), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
